// File: rtl/regfile_scoreboard.sv
// Integer register file with writeback bypass and a per-register busy scoreboard.
// Holds issue back whenever a source or destination register still has a writeback pending.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic              issue_ready,
  output logic              stall,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] write_data,
  output logic [NREGS-1:0]  busy,
  output logic              wb_err
);

  // Issue handshake: an instruction issues on a rising edge where issue_valid and
  // issue_ready are both high. issue_ready never depends on issue_valid, and
  // issue_valid may be raised or dropped at any time.

  localparam logic BYP = (BYPASS != 0);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wb_clr;
  logic              issue_fire;
  logic              haz1;
  logic              haz2;
  logic              waw;

  assign wb_clr = wb_valid && (wb_rd != '0);

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) begin
      if (BYP && wb_valid && (wb_rd == rs1_addr)) rs1_data = write_data;
      else                                        rs1_data = regs[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) begin
      if (BYP && wb_valid && (wb_rd == rs2_addr)) rs2_data = write_data;
      else                                        rs2_data = regs[rs2_addr];
    end
  end

  // A writeback in flight this cycle only resolves a read hazard when it is bypassed,
  // but always resolves a WAW hazard because the set takes priority over the clear.
  assign haz1 = rs1_used && (rs1_addr != '0) && busy[rs1_addr]
                && !(wb_clr && (wb_rd == rs1_addr) && BYP);
  assign haz2 = rs2_used && (rs2_addr != '0) && busy[rs2_addr]
                && !(wb_clr && (wb_rd == rs2_addr) && BYP);
  assign waw  = (issue_rd != '0) && busy[issue_rd] && !(wb_clr && (wb_rd == issue_rd));

  assign issue_ready = !(haz1 || haz2 || waw);
  assign stall       = issue_valid && !issue_ready;
  assign issue_fire  = issue_valid && issue_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_clr) begin
      regs[wb_rd] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      if (wb_clr && !busy[wb_rd]) wb_err <= 1'b1;
      for (int i = 1; i < NREGS; i++) begin
        if (issue_fire && (issue_rd == AW'(i)))  busy[i] <= 1'b1;
        else if (wb_clr && (wb_rd == AW'(i)))    busy[i] <= 1'b0;
      end
      busy[0] <= 1'b0;
    end
  end

endmodule
